// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with M/W->E operand forwarding and Tnew tracking.
// Optional macro ID_EX_BUBBLE_CNT_EN adds a 32-bit bubble counter output.
module id_ex_stage #(
  parameter int DW = 32,
  parameter int RW = 5,
  parameter int TW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic [DW-1:0] d_pc,
  input  logic [DW-1:0] d_instr,
  input  logic [DW-1:0] d_rs_data,
  input  logic [DW-1:0] d_rt_data,
  input  logic [DW-1:0] d_imm32,
  input  logic [RW-1:0] d_rs,
  input  logic [RW-1:0] d_rt,
  input  logic [RW-1:0] d_dst,
  input  logic          d_alusrc,
  input  logic          d_cin,
  input  logic          d_aluop,
  input  logic          d_lui,
  input  logic          d_add,
  input  logic          d_regwrite,
  input  logic          d_memwrite,
  input  logic          d_memtoreg,
  input  logic [TW-1:0] d_tnew,
  input  logic [RW-1:0] m_dst,
  input  logic          m_regwrite,
  input  logic          m_ready,
  input  logic [DW-1:0] m_data,
  input  logic [RW-1:0] w_dst,
  input  logic          w_regwrite,
  input  logic [DW-1:0] w_data,
  output logic [DW-1:0] e_w1,
  output logic [DW-1:0] e_w2,
  output logic          e_cin,
  output logic          e_aluop,
  output logic          e_lui,
  output logic          e_add,
  output logic [DW-1:0] e_store_data,
  output logic [DW-1:0] e_pc,
  output logic [DW-1:0] e_instr,
  output logic [RW-1:0] e_rs,
  output logic [RW-1:0] e_rt,
  output logic [RW-1:0] e_dst,
  output logic          e_regwrite,
  output logic          e_memwrite,
  output logic          e_memtoreg,
  output logic [TW-1:0] e_tnew,
  output logic [TW-1:0] e_tnew_next
`ifdef ID_EX_BUBBLE_CNT_EN
  ,
  output logic [31:0]   bubble_cnt
`endif
);

  typedef struct packed {
    logic [DW-1:0] pc;
    logic [DW-1:0] instr;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm32;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [RW-1:0] dst;
    logic          alusrc;
    logic          cin;
    logic          aluop;
    logic          lui;
    logic          add;
    logic          regwrite;
    logic          memwrite;
    logic          memtoreg;
    logic [TW-1:0] tnew;
  } id_ex_t;

  id_ex_t d, q;
  logic [DW-1:0] fwd_rs, fwd_rt;

  always_comb begin
    d          = '0;
    d.pc       = d_pc;
    d.instr    = d_instr;
    d.rs_data  = d_rs_data;
    d.rt_data  = d_rt_data;
    d.imm32    = d_imm32;
    d.rs       = d_rs;
    d.rt       = d_rt;
    d.dst      = d_dst;
    d.alusrc   = d_alusrc;
    d.cin      = d_cin;
    d.aluop    = d_aluop;
    d.lui      = d_lui;
    d.add      = d_add;
    d.regwrite = d_regwrite;
    d.memwrite = d_memwrite;
    d.memtoreg = d_memtoreg;
    d.tnew     = d_tnew;
  end

  // a bubble keeps only the PC so exceptions can still name the slot
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (stall) begin
      q    <= '0;
      q.pc <= d_pc;
    end else begin
      q <= d;
    end
  end

`ifdef ID_EX_BUBBLE_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)
      bubble_cnt <= '0;
    else if (stall)
      bubble_cnt <= bubble_cnt + 32'd1;
  end
`endif

  // M beats W; r0 is never bypassed
  always_comb begin
    fwd_rs = q.rs_data;
    if (q.rs != '0) begin
      if (m_regwrite && m_ready && m_dst == q.rs)
        fwd_rs = m_data;
      else if (w_regwrite && w_dst == q.rs)
        fwd_rs = w_data;
    end
  end

  always_comb begin
    fwd_rt = q.rt_data;
    if (q.rt != '0) begin
      if (m_regwrite && m_ready && m_dst == q.rt)
        fwd_rt = m_data;
      else if (w_regwrite && w_dst == q.rt)
        fwd_rt = w_data;
    end
  end

  assign e_w1         = fwd_rs;
  assign e_w2         = q.alusrc ? q.imm32 : fwd_rt;
  assign e_store_data = fwd_rt;
  assign e_cin        = q.cin;
  assign e_aluop      = q.aluop;
  assign e_lui        = q.lui;
  assign e_add        = q.add;
  assign e_pc         = q.pc;
  assign e_instr      = q.instr;
  assign e_rs         = q.rs;
  assign e_rt         = q.rt;
  assign e_dst        = q.dst;
  assign e_regwrite   = q.regwrite;
  assign e_memwrite   = q.memwrite;
  assign e_memtoreg   = q.memtoreg;
  assign e_tnew       = q.tnew;
  assign e_tnew_next  = (q.tnew == '0) ? '0 : q.tnew - TW'(1);

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed plan cases then random traffic.
// Expected E-stage views are queued by the driver and popped by a monitor.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset, stall;
  logic [31:0] d_pc, d_instr, d_rs_data, d_rt_data, d_imm32;
  logic [4:0]  d_rs, d_rt, d_dst;
  logic        d_alusrc, d_cin, d_aluop, d_lui, d_add;
  logic        d_regwrite, d_memwrite, d_memtoreg;
  logic [1:0]  d_tnew;
  logic [4:0]  m_dst, w_dst;
  logic        m_regwrite, m_ready, w_regwrite;
  logic [31:0] m_data, w_data;
  logic [31:0] e_w1, e_w2, e_store_data, e_pc, e_instr;
  logic        e_cin, e_aluop, e_lui, e_add;
  logic [4:0]  e_rs, e_rt, e_dst;
  logic        e_regwrite, e_memwrite, e_memtoreg;
  logic [1:0]  e_tnew, e_tnew_next;
`ifdef ID_EX_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt;
`endif

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .stall(stall),
    .d_pc(d_pc), .d_instr(d_instr),
    .d_rs_data(d_rs_data), .d_rt_data(d_rt_data),
    .d_imm32(d_imm32),
    .d_rs(d_rs), .d_rt(d_rt), .d_dst(d_dst),
    .d_alusrc(d_alusrc), .d_cin(d_cin),
    .d_aluop(d_aluop), .d_lui(d_lui), .d_add(d_add),
    .d_regwrite(d_regwrite), .d_memwrite(d_memwrite),
    .d_memtoreg(d_memtoreg), .d_tnew(d_tnew),
    .m_dst(m_dst), .m_regwrite(m_regwrite),
    .m_ready(m_ready), .m_data(m_data),
    .w_dst(w_dst), .w_regwrite(w_regwrite),
    .w_data(w_data),
    .e_w1(e_w1), .e_w2(e_w2),
    .e_cin(e_cin), .e_aluop(e_aluop),
    .e_lui(e_lui), .e_add(e_add),
    .e_store_data(e_store_data),
    .e_pc(e_pc), .e_instr(e_instr),
    .e_rs(e_rs), .e_rt(e_rt), .e_dst(e_dst),
    .e_regwrite(e_regwrite), .e_memwrite(e_memwrite),
    .e_memtoreg(e_memtoreg),
    .e_tnew(e_tnew), .e_tnew_next(e_tnew_next)
`ifdef ID_EX_BUBBLE_CNT_EN
    , .bubble_cnt(bubble_cnt)
`endif
  );

  typedef struct {
    logic [31:0] pc, instr, rsd, rtd, imm;
    logic [4:0]  rs, rt, dst;
    logic        alusrc, cin, aluop, lui, add;
    logic        rw, mw, mtr;
    int          tnew;
  } ins_t;

  typedef struct {
    logic [31:0] w1, w2, sd, pc, instr;
    logic [4:0]  rs, rt, dst;
    logic [3:0]  ops;
    logic [2:0]  ctl;
    int          tnew, tnn;
    logic [31:0] bc;
  } exp_t;

  exp_t        sb[$];
  ins_t        e;
  logic [31:0] bcnt;
  int          total = 0;
  int          bad = 0;

  task automatic check(input string n,
                       input logic [31:0] a,
                       input logic [31:0] x);
    total++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", n, a, x);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] r,
                                      input logic [31:0] v);
    if (r == 5'd0) return v;
    if (m_regwrite && m_ready && m_dst == r) return m_data;
    if (w_regwrite && w_dst == r) return w_data;
    return v;
  endfunction

  // what the instruction in E becomes after this edge
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      e = '{default: '0};
      bcnt = 32'd0;
    end else if (stall) begin
      e = '{default: '0};
      e.pc = d_pc;
      bcnt = bcnt + 32'd1;
    end else begin
      e.pc = d_pc;       e.instr = d_instr;
      e.rsd = d_rs_data; e.rtd = d_rt_data;
      e.imm = d_imm32;
      e.rs = d_rs; e.rt = d_rt; e.dst = d_dst;
      e.alusrc = d_alusrc; e.cin = d_cin;
      e.aluop = d_aluop; e.lui = d_lui; e.add = d_add;
      e.rw = d_regwrite; e.mw = d_memwrite;
      e.mtr = d_memtoreg;
      e.tnew = int'(d_tnew);
    end
    #1;
  endtask

  task automatic expect_now();
    exp_t x;
    x.w1 = fwd(e.rs, e.rsd);
    x.sd = fwd(e.rt, e.rtd);
    x.w2 = e.alusrc ? e.imm : x.sd;
    x.pc = e.pc;
    x.instr = e.instr;
    x.rs = e.rs; x.rt = e.rt; x.dst = e.dst;
    x.ops = {e.cin, e.aluop, e.lui, e.add};
    x.ctl = {e.rw, e.mw, e.mtr};
    x.tnew = e.tnew;
    x.tnn = (e.tnew > 0) ? e.tnew - 1 : 0;
    x.bc = bcnt;
    sb.push_back(x);
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      check("w1", e_w1, x.w1);
      check("w2", e_w2, x.w2);
      check("store_data", e_store_data, x.sd);
      check("pc", e_pc, x.pc);
      check("instr", e_instr, x.instr);
      check("rs", 32'(e_rs), 32'(x.rs));
      check("rt", 32'(e_rt), 32'(x.rt));
      check("dst", 32'(e_dst), 32'(x.dst));
      check("ops", 32'({e_cin, e_aluop, e_lui, e_add}),
            32'(x.ops));
      check("ctl",
            32'({e_regwrite, e_memwrite, e_memtoreg}),
            32'(x.ctl));
      check("tnew", 32'(e_tnew), 32'(x.tnew));
      check("tnew_next", 32'(e_tnew_next), 32'(x.tnn));
`ifdef ID_EX_BUBBLE_CNT_EN
      check("bubble_cnt", bubble_cnt, x.bc);
`endif
    end
  end

  task automatic clr_d();
    d_pc = '0; d_instr = '0;
    d_rs_data = '0; d_rt_data = '0; d_imm32 = '0;
    d_rs = '0; d_rt = '0; d_dst = '0;
    d_alusrc = 0; d_cin = 0; d_aluop = 0;
    d_lui = 0; d_add = 0;
    d_regwrite = 0; d_memwrite = 0; d_memtoreg = 0;
    d_tnew = '0;
  endtask

  task automatic no_mw();
    m_dst = 5'd1; m_regwrite = 0; m_ready = 0;
    m_data = 32'h0;
    w_dst = 5'd2; w_regwrite = 0; w_data = 32'h0;
  endtask

  task automatic rand_in();
    int op;
    d_pc = $urandom; d_instr = $urandom;
    d_rs_data = $urandom; d_rt_data = $urandom;
    d_imm32 = $urandom;
    d_rs = 5'($urandom_range(0, 3));
    d_rt = 5'($urandom_range(0, 3));
    d_dst = 5'($urandom_range(0, 31));
    d_alusrc = 1'($urandom_range(0, 1));
    op = $urandom_range(0, 4);
    d_cin = (op == 1); d_aluop = (op == 2);
    d_lui = (op == 3); d_add = (op == 4);
    d_regwrite = 1'($urandom_range(0, 1));
    d_memwrite = 1'($urandom_range(0, 1));
    d_memtoreg = 1'($urandom_range(0, 1));
    d_tnew = 2'($urandom_range(0, 3));
    m_dst = 5'($urandom_range(0, 3));
    m_regwrite = 1'($urandom_range(0, 1));
    m_ready = 1'($urandom_range(0, 1));
    m_data = $urandom;
    w_dst = 5'($urandom_range(0, 3));
    w_regwrite = 1'($urandom_range(0, 1));
    w_data = $urandom;
    stall = ($urandom_range(0, 4) == 0);
    reset = ($urandom_range(0, 19) == 0);
  endtask

  initial begin
    bcnt = '0;
    e = '{default: '0};
    rand_in();
    reset = 1; stall = 0;
    tick();
    reset = 0;
    clr_d(); no_mw();
    d_rs = 5'd8; d_rs_data = 32'h0000_F0F0;
    d_imm32 = 32'h0000_000F;
    d_alusrc = 1; d_aluop = 1;
    expect_now();
    tick();
    clr_d();
    d_rs = 5'd9; d_rs_data = 32'h55;
    m_dst = 5'd9; m_regwrite = 1; m_ready = 1;
    m_data = 32'h11;
    w_dst = 5'd9; w_regwrite = 1; w_data = 32'h22;
    expect_now();
    tick();
    expect_now();
    tick();
    m_regwrite = 0;
    expect_now();
    d_rs = 5'd0; d_rs_data = 32'h0;
    tick();
    m_dst = 5'd0; m_regwrite = 1; m_ready = 1;
    m_data = 32'hDEAD;
    w_dst = 5'd0; w_regwrite = 1;
    expect_now();
    stall = 1; d_pc = 32'h3010; d_regwrite = 1;
    d_instr = $urandom;
    repeat (3) begin
      tick();
      expect_now();
    end
    stall = 0; no_mw();
    clr_d(); d_tnew = 2'd2; d_pc = 32'h3014;
    tick();
    expect_now();
    d_tnew = 2'd0;
    tick();
    expect_now();
    reset = 1; stall = 1;
    tick();
    reset = 0; stall = 0;
    expect_now();
    repeat (400) begin
      tick();
      rand_in();
      expect_now();
    end
    reset = 0; stall = 0;
    repeat (2) @(negedge clk);
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL drain actual=%0d required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
